// File: rtl/burst_counter_if.sv
// burst_counter bus: done strobes, config and completion outputs.
// BURST_COUNTER_STATS_EN adds the per-channel burst_cnt output.
interface burst_counter_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 4
);
  logic [NUM_CH-1:0]       done;
  logic                    clear;
  logic                    cfg_load;
  logic [CNT_W-1:0]        cfg_target;
  logic                    oneshot;
  logic [NUM_CH-1:0]       en_y;
  logic [NUM_CH*CNT_W-1:0] count;
  logic                    all_y;
  logic [CNT_W-1:0]        target;
`ifdef BURST_COUNTER_STATS_EN
  logic [NUM_CH*8-1:0]     burst_cnt;

  modport master (
    output done, clear, cfg_load,
    output cfg_target, oneshot,
    input  en_y, count, all_y,
    input  target, burst_cnt
  );
  modport slave (
    input  done, clear, cfg_load,
    input  cfg_target, oneshot,
    output en_y, count, all_y,
    output target, burst_cnt
  );
`else
  modport master (
    output done, clear, cfg_load,
    output cfg_target, oneshot,
    input  en_y, count, all_y,
    input  target
  );
  modport slave (
    input  done, clear, cfg_load,
    input  cfg_target, oneshot,
    output en_y, count, all_y,
    output target
  );
`endif
endinterface

// File: rtl/burst_counter.sv
// Per-channel done-strobe burst counter with programmable target.
// Optional stats: define BURST_COUNTER_STATS_EN for burst_cnt.
module burst_counter #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 4,
  parameter int DEFAULT_TARGET = 7
) (
  input logic         clk,
  input logic         reset,
  burst_counter_if.slave bus
);

  typedef enum logic {
    S_COUNT,
    S_PARKED
  } state_t;

  state_t            r_st   [NUM_CH];
  state_t            w_st   [NUM_CH];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [CNT_W-1:0]  w_cnt  [NUM_CH];
  logic [NUM_CH-1:0] r_en_y;
  logic [NUM_CH-1:0] w_en_y;
  logic [NUM_CH-1:0] r_seen;
  logic [NUM_CH-1:0] w_seen;
  logic              r_all_y;
  logic              w_all_y;
  logic [CNT_W-1:0]  r_tgt;
  logic [CNT_W-1:0]  w_tgt;
  logic [NUM_CH*CNT_W-1:0] w_count;

  // State register for all channels and the shared target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_st[i]  <= S_COUNT;
        r_cnt[i] <= '0;
      end
      r_en_y  <= '0;
      r_seen  <= '0;
      r_all_y <= 1'b0;
      r_tgt   <= CNT_W'(DEFAULT_TARGET);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_st[i]  <= w_st[i];
        r_cnt[i] <= w_cnt[i];
      end
      r_en_y  <= w_en_y;
      r_seen  <= w_seen;
      r_all_y <= w_all_y;
      r_tgt   <= w_tgt;
    end
  end

  // Next state: clear wins, else count/wrap per channel
  always_comb begin
    w_en_y  = '0;
    w_seen  = r_seen;
    w_all_y = r_all_y | (&r_seen);
    w_tgt   = r_tgt;
    for (int i = 0; i < NUM_CH; i++) begin
      w_st[i]  = r_st[i];
      w_cnt[i] = r_cnt[i];
    end
    if (bus.cfg_load) begin
      w_tgt = (bus.cfg_target == '0) ?
              CNT_W'(1) : bus.cfg_target;
    end
    if (bus.clear) begin
      w_seen  = '0;
      w_all_y = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        w_st[i]  = S_COUNT;
        w_cnt[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_st[i] == S_COUNT && bus.done[i]) begin
          if (({1'b0, r_cnt[i]} + (CNT_W+1)'(1))
              >= {1'b0, r_tgt}) begin
            w_cnt[i]  = '0;
            w_en_y[i] = 1'b1;
            w_seen[i] = 1'b1;
            if (bus.oneshot) w_st[i] = S_PARKED;
          end else begin
            w_cnt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
      end
    end
  end

  // Pack per-channel counts onto the flat output bus
  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_count[i*CNT_W +: CNT_W] = r_cnt[i];
    end
  end

  assign bus.count  = w_count;
  assign bus.en_y   = r_en_y;
  assign bus.all_y  = r_all_y;
  assign bus.target = r_tgt;

`ifdef BURST_COUNTER_STATS_EN
  logic [7:0]          r_bcnt [NUM_CH];
  logic [NUM_CH*8-1:0] w_bcnt;

  // Saturating count of en_y pulses per channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        r_bcnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.clear)
          r_bcnt[i] <= '0;
        else if (r_en_y[i] && r_bcnt[i] != 8'hFF)
          r_bcnt[i] <= r_bcnt[i] + 8'd1;
      end
    end
  end

  // Pack burst counts onto the flat output bus
  always_comb begin
    w_bcnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_bcnt[i*8 +: 8] = r_bcnt[i];
    end
  end

  assign bus.burst_cnt = w_bcnt;
`endif

endmodule

// File: tb/tb_burst_counter.sv
// Directed self-checking bench for burst_counter.
// Stats checks compile in with BURST_COUNTER_STATS_EN.
module tb_burst_counter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  burst_counter_if #(.NUM_CH(4), .CNT_W(4)) bus ();

  burst_counter #(
    .NUM_CH(4),
    .CNT_W(4),
    .DEFAULT_TARGET(7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [3:0] m);
    bus.done = m;
    step();
    bus.done = '0;
  endtask

  task automatic load(input logic [3:0] t);
    bus.cfg_load   = 1'b1;
    bus.cfg_target = t;
    step();
    bus.cfg_load   = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  initial begin
    logic [3:0] m;
    logic [3:0] e;
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.done       = '0;
    bus.clear      = 1'b0;
    bus.cfg_load   = 1'b0;
    bus.cfg_target = '0;
    bus.oneshot    = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_count", 32'(bus.count), 32'h0);
    chk("rst_en_y", 32'(bus.en_y), 32'h0);
    chk("rst_all_y", 32'(bus.all_y), 32'h0);
    chk("rst_target", 32'(bus.target), 32'h7);

    // ch0: 7 spaced strobes, twice
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 6; k++) begin
        strobe(4'b0001);
        step();
      end
      chk("gap_cnt6", 32'(bus.count), 32'h6);
      chk("gap_pre_en", 32'(bus.en_y), 32'h0);
      strobe(4'b0001);
      chk("gap_en", 32'(bus.en_y), 32'h1);
      chk("gap_wrap", 32'(bus.count), 32'h0);
      step();
      chk("gap_en_1cyc", 32'(bus.en_y), 32'h0);
    end

    // ch1: target 3, back-to-back
    load(4'd3);
    chk("tgt3", 32'(bus.target), 32'h3);
    for (int k = 0; k < 6; k++) begin
      bus.done = 4'b0010;
      step();
      e = (k % 3 == 2) ? 4'b0010 : 4'b0000;
      chk("t3_en", 32'(bus.en_y), 32'(e));
    end
    bus.done = '0;
    step();
    load(4'd0);
    chk("tgt0_clamp", 32'(bus.target), 32'h1);
    for (int k = 0; k < 3; k++) begin
      bus.done = 4'b0010;
      step();
      chk("t1_en", 32'(bus.en_y), 32'h2);
    end
    bus.done = '0;
    step();
    chk("t1_idle", 32'(bus.en_y), 32'h0);
    load(4'd7);

    // ch2: oneshot parks, clear unparks
    bus.oneshot = 1'b1;
    for (int k = 0; k < 7; k++) begin
      bus.done = 4'b0100;
      step();
    end
    chk("os_en", 32'(bus.en_y), 32'h4);
    bus.oneshot = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.done = 4'b0100;
      step();
      chk("park_en", 32'(bus.en_y), 32'h0);
    end
    bus.done = '0;
    chk("park_cnt", 32'(bus.count), 32'h0);
    chk("no_all_y", 32'(bus.all_y), 32'h0);
    do_clear();
    chk("clr_all_y", 32'(bus.all_y), 32'h0);

    // all channels, staggered by one cycle
    for (int c = 0; c < 10; c++) begin
      m = '0;
      e = '0;
      for (int i = 0; i < 4; i++) begin
        m[i] = (c >= i) && (c < i + 7);
        e[i] = (c == i + 6);
      end
      bus.done = m;
      step();
      chk("stag_en", 32'(bus.en_y), 32'(e));
    end
    bus.done = '0;
    chk("stag_all_y0", 32'(bus.all_y), 32'h0);
    step();
    chk("stag_all_y1", 32'(bus.all_y), 32'h1);
    for (int k = 0; k < 7; k++) begin
      bus.done = 4'hF;
      step();
    end
    bus.done = '0;
    chk("par_en", 32'(bus.en_y), 32'hF);
    step();
    chk("all_y_sticky", 32'(bus.all_y), 32'h1);
    do_clear();
    chk("all_y_clr", 32'(bus.all_y), 32'h0);

    // done with cfg_load uses the old target
    for (int k = 0; k < 5; k++) begin
      bus.done = 4'b0001;
      step();
    end
    chk("pre_cnt5", 32'(bus.count), 32'h5);
    bus.cfg_load   = 1'b1;
    bus.cfg_target = 4'd4;
    step();
    bus.cfg_load = 1'b0;
    chk("ld_cnt6", 32'(bus.count), 32'h6);
    chk("ld_en0", 32'(bus.en_y), 32'h0);
    chk("ld_tgt4", 32'(bus.target), 32'h4);
    step();
    bus.done = '0;
    chk("ld_fire", 32'(bus.en_y), 32'h1);
    chk("ld_wrap", 32'(bus.count), 32'h0);
    strobe(4'b0001);
    chk("pre_clr", 32'(bus.count), 32'h1);
    bus.done  = 4'b0001;
    bus.clear = 1'b1;
    step();
    bus.done  = '0;
    bus.clear = 1'b0;
    chk("clr_pri_cnt", 32'(bus.count), 32'h0);
    chk("clr_pri_en", 32'(bus.en_y), 32'h0);
    load(4'd3);
    chk("keep_tgt", 32'(bus.target), 32'h3);

    // async reset mid-burst
    strobe(4'b0001);
    strobe(4'b0001);
    chk("mid_cnt2", 32'(bus.count), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_cnt", 32'(bus.count), 32'h0);
    chk("arst_tgt", 32'(bus.target), 32'h7);
    step();
    reset = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      bus.done = 4'b0001;
      step();
      chk("post_rst_en", 32'(bus.en_y), 32'h0);
    end
    bus.done = 4'b0001;
    step();
    bus.done = '0;
    chk("post_rst_fire", 32'(bus.en_y), 32'h1);
    step();

`ifdef BURST_COUNTER_STATS_EN
    chk("bc_one", 32'(bus.burst_cnt), 32'h1);
    load(4'd1);
    for (int k = 0; k < 256; k++) begin
      bus.done = 4'b0001;
      step();
    end
    bus.done = '0;
    step();
    step();
    chk("bc_sat", 32'(bus.burst_cnt), 32'hFF);
    do_clear();
    chk("bc_clr", 32'(bus.burst_cnt), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
